// File: rtl/pattern_scheduler_if.sv
// Control/status bundle between the pattern scheduler and the VGA front end.
// The master side is the scheduler; the slave side owns vsync, the mode level and the buttons.
interface pattern_scheduler_if;
  logic       vsync;
  logic       auto_en;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_pause;
  logic       btn_speed;
  logic [1:0] pattern_sel;
  logic       pattern_rst;
  logic       frame_tick;
  logic       paused;
  logic [2:0] step_size;
  logic       blank;

  modport master (
    input  vsync, auto_en, btn_next, btn_prev, btn_pause, btn_speed,
    output pattern_sel, pattern_rst, frame_tick, paused, step_size, blank
  );

  modport slave (
    output vsync, auto_en, btn_next, btn_prev, btn_pause, btn_speed,
    input  pattern_sel, pattern_rst, frame_tick, paused, step_size, blank
  );
endinterface

// File: rtl/pattern_scheduler.sv
// Sequences the VGA pattern generators: debounced buttons, timed auto-advance and
// frame-aligned pattern switches followed by a short blanking window.
module pattern_scheduler #(
  parameter int unsigned NUM_PATTERNS    = 3,
  parameter int unsigned DWELL_FRAMES    = 300,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BLANK_FRAMES    = 2
) (
  input logic                 clk,
  input logic                 rst,
  pattern_scheduler_if.master pif
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DwW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int unsigned BkW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DwW-1:0] DwellLast = DwW'(DWELL_FRAMES - 1);
  localparam logic [BkW-1:0] BlankLast = BkW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
  localparam logic [1:0]     SelLast   = 2'(NUM_PATTERNS - 1);

  localparam logic [0:0] StShow  = 1'b0;
  localparam logic [0:0] StBlank = 1'b1;

  localparam logic [1:0] PendNone = 2'd0;
  localparam logic [1:0] PendNext = 2'd1;
  localparam logic [1:0] PendPrev = 2'd2;

  localparam int unsigned BtnNext  = 0;
  localparam int unsigned BtnPrev  = 1;
  localparam int unsigned BtnPause = 2;
  localparam int unsigned BtnSpeed = 3;

  // Button synchronizers and debouncers
  logic [3:0]     btn_raw;
  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     db_q;
  logic [3:0]     press_q;
  logic [DbW-1:0] db_cnt_q [4];

  assign btn_raw = {pif.btn_speed, pif.btn_pause, pif.btn_prev, pif.btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Frame-level control
  logic           vsync_q, vrise;
  logic [0:0]     state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     pend_q, pend_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [BkW-1:0] bcnt_q, bcnt_d;
  logic           prst_q, prst_d;
  logic           tick_q, tick_d;
  logic           paused_q, paused_d;
  logic [2:0]     step_q, step_d;
  logic           blank_q, blank_d;
  logic           do_switch, go_next;

  assign vrise = pif.vsync & ~vsync_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    dwell_d   = dwell_q;
    bcnt_d    = bcnt_q;
    prst_d    = 1'b0;
    tick_d    = 1'b0;
    blank_d   = blank_q;
    paused_d  = paused_q ^ press_q[BtnPause];
    step_d    = step_q;
    do_switch = 1'b0;
    go_next   = 1'b1;

    if (press_q[BtnSpeed]) step_d = (step_q == 3'd7) ? 3'd1 : step_q + 3'd1;

    if (vrise) begin
      case (state_q)
        StShow: begin
          if (pend_q != PendNone) begin
            do_switch = 1'b1;
            go_next   = (pend_q == PendNext);
            pend_d    = PendNone;
          end else if (pif.auto_en && !paused_q && dwell_q == DwellLast) begin
            do_switch = 1'b1;
          end else begin
            tick_d = ~paused_q;
            if (!pif.auto_en)  dwell_d = '0;
            else if (!paused_q) dwell_d = dwell_q + DwW'(1);
          end
        end
        default: begin
          if (bcnt_q == BlankLast) begin
            blank_d = 1'b0;
            bcnt_d  = '0;
            state_d = StShow;
          end else begin
            bcnt_d = bcnt_q + BkW'(1);
          end
        end
      endcase
    end

    if (do_switch) begin
      if (go_next) sel_d = (sel_q == SelLast) ? 2'd0 : sel_q + 2'd1;
      else         sel_d = (sel_q == 2'd0) ? SelLast : sel_q - 2'd1;
      prst_d  = 1'b1;
      dwell_d = '0;
      if (BLANK_FRAMES > 0) begin
        blank_d = 1'b1;
        bcnt_d  = '0;
        state_d = StBlank;
      end
    end

    // A press in the same cycle as a consumed request survives for the next frame.
    if (press_q[BtnNext])      pend_d = PendNext;
    else if (press_q[BtnPrev]) pend_d = PendPrev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b1;
      state_q  <= StShow;
      sel_q    <= '0;
      pend_q   <= PendNone;
      dwell_q  <= '0;
      bcnt_q   <= '0;
      prst_q   <= 1'b0;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
      step_q   <= 3'd1;
      blank_q  <= 1'b0;
    end else begin
      vsync_q  <= pif.vsync;
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      dwell_q  <= dwell_d;
      bcnt_q   <= bcnt_d;
      prst_q   <= prst_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
      step_q   <= step_d;
      blank_q  <= blank_d;
    end
  end

  assign pif.pattern_sel = sel_q;
  assign pif.pattern_rst = prst_q;
  assign pif.frame_tick  = tick_q;
  assign pif.paused      = paused_q;
  assign pif.step_size   = step_q;
  assign pif.blank       = blank_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: frame-level scoreboard of expected outputs, pushed when
// a vsync edge or button press is driven and popped when the registered outputs settle.
module tb_pattern_scheduler;
  localparam int unsigned NumPat = 3;
  localparam int unsigned Dwell  = 5;
  localparam int unsigned Deb    = 4;
  localparam int unsigned Blank  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pattern_scheduler_if pif ();

  pattern_scheduler #(
    .NUM_PATTERNS    (NumPat),
    .DWELL_FRAMES    (Dwell),
    .DEBOUNCE_CYCLES (Deb),
    .BLANK_FRAMES    (Blank)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int tick;
    int rstp;
    int blank;
    int paused;
    int step;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Frame-level reference state
  int m_sel, m_dwell, m_left, m_pend, m_paused, m_step;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_dwell = 0; m_left = 0; m_pend = 0; m_paused = 0; m_step = 1;
  endtask

  task automatic push_exp(input int tick, input int rstp);
    exp_t e;
    e.sel = m_sel; e.tick = tick; e.rstp = rstp;
    e.blank = (m_left > 0) ? 1 : 0; e.paused = m_paused; e.step = m_step;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check_eq("pattern_sel", 8'(pif.pattern_sel), 8'(e.sel));
      check_eq("frame_tick",  8'(pif.frame_tick),  8'(e.tick));
      check_eq("pattern_rst", 8'(pif.pattern_rst), 8'(e.rstp));
      check_eq("blank",       8'(pif.blank),       8'(e.blank));
      check_eq("paused",      8'(pif.paused),      8'(e.paused));
      check_eq("step_size",   8'(pif.step_size),   8'(e.step));
    end
  endtask

  // One vsync period; the rising edge is the frame boundary.
  task automatic frame();
    int tick = 0;
    int rstp = 0;
    @(negedge clk) pif.vsync = 1'b0;
    repeat (3) @(negedge clk);
    pif.vsync = 1'b1;
    if (m_left > 0) begin
      m_left--;
    end else if (m_pend != 0 || (pif.auto_en && m_paused == 0 && m_dwell == Dwell - 1)) begin
      m_sel   = (m_pend == 2) ? (m_sel + NumPat - 1) % NumPat : (m_sel + 1) % NumPat;
      m_pend  = 0;
      m_dwell = 0;
      m_left  = Blank;
      rstp    = 1;
    end else begin
      tick = (m_paused == 0) ? 1 : 0;
      if (!pif.auto_en)      m_dwell = 0;
      else if (m_paused == 0) m_dwell++;
    end
    push_exp(tick, rstp);
    @(posedge clk); #1;
    compare_out();
    @(posedge clk); #1;
    check_eq("tick_one_cycle", 8'(pif.frame_tick), 8'd0);
    check_eq("rst_one_cycle",  8'(pif.pattern_rst), 8'd0);
  endtask

  // idx: 0 next, 1 prev, 2 pause, 3 speed; take says whether a press is expected.
  task automatic press(input int idx, input int hold, input bit take);
    @(negedge clk);
    case (idx)
      0: pif.btn_next  = 1'b1;
      1: pif.btn_prev  = 1'b1;
      2: pif.btn_pause = 1'b1;
      default: pif.btn_speed = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    pif.btn_next = 1'b0; pif.btn_prev = 1'b0; pif.btn_pause = 1'b0; pif.btn_speed = 1'b0;
    repeat (12) @(negedge clk);
    if (take) begin
      case (idx)
        0: m_pend = 1;
        1: m_pend = 2;
        2: m_paused = 1 - m_paused;
        default: m_step = (m_step == 7) ? 1 : m_step + 1;
      endcase
    end
    push_exp(0, 0);
    compare_out();
  endtask

  int speed_seq [7] = '{2, 3, 4, 5, 6, 7, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    pif.vsync = 1'b1; pif.auto_en = 1'b1;
    pif.btn_next = 1'b0; pif.btn_prev = 1'b0; pif.btn_pause = 1'b0; pif.btn_speed = 1'b0;
    model_reset();
    #12;
    push_exp(0, 0);
    compare_out();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Auto-advance after the dwell, then two blank frames
    repeat (8) frame();

    // Manual navigation with auto disabled
    pif.auto_en = 1'b0;
    frame();
    press(0, 3, 1'b0);
    frame();
    press(0, 6, 1'b1);
    frame();
    repeat (2) frame();
    press(0, 6, 1'b1);
    frame();
    repeat (2) frame();
    press(1, 6, 1'b1);
    frame();
    repeat (2) frame();
    press(0, 6, 1'b1);
    press(1, 6, 1'b1);
    frame();
    repeat (3) frame();

    // Pause freezes the dwell count
    pif.auto_en = 1'b1;
    repeat (2) frame();
    press(2, 6, 1'b1);
    repeat (10) frame();
    press(2, 6, 1'b1);
    repeat (5) frame();

    // Speed cycling
    pif.auto_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      press(3, 6, 1'b1);
      check_eq("speed_seq", 8'(pif.step_size), 8'(speed_seq[i]));
    end
    press(3, 6, 1'b1);
    press(2, 6, 1'b1);

    // Reset in the middle of a blank window with a request pending
    press(0, 6, 1'b1);
    frame();
    press(0, 6, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_eq("rst_sel",    8'(pif.pattern_sel), 8'd0);
    check_eq("rst_prst",   8'(pif.pattern_rst), 8'd0);
    check_eq("rst_tick",   8'(pif.frame_tick),  8'd0);
    check_eq("rst_paused", 8'(pif.paused),      8'd0);
    check_eq("rst_step",   8'(pif.step_size),   8'd1);
    check_eq("rst_blank",  8'(pif.blank),       8'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
